// File: rtl/rk8e_break_initiator_if.sv
// Data break port between the RK8E break initiator and the CPU break responder.
interface rk8e_break_initiator_if #(
  parameter int unsigned FIELD_W = 3
);
  localparam int unsigned AW = 12;

  logic               data_break;
  logic               to_disk;
  logic               break_in_prog;
  logic [AW-1:0]      mem_rdata;
  logic [FIELD_W-1:0] db_field;
  logic [AW-1:0]      db_addr;
  logic [AW-1:0]      db_wdata;

  modport master (
    output data_break, to_disk, db_field, db_addr, db_wdata,
    input  break_in_prog, mem_rdata
  );

  modport slave (
    input  data_break, to_disk, db_field, db_addr, db_wdata,
    output break_in_prog, mem_rdata
  );
endinterface

// File: rtl/rk8e_break_initiator.sv
// RK8E data break initiator: moves a block of 12-bit words between the sector
// buffer and memory, one CPU break per word.
module rk8e_break_initiator #(
  parameter int unsigned FIELD_W = 3,
  parameter int unsigned WC_W    = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic               i_dir_to_disk,
  input  logic [FIELD_W-1:0] i_start_field,
  input  logic [11:0]        i_start_addr,
  input  logic [WC_W-1:0]    i_start_wc,
  input  logic               i_buf_valid,
  input  logic [11:0]        i_buf_data,
  output logic               o_buf_pop,
  input  logic               i_out_ready,
  output logic               o_out_push,
  output logic [11:0]        o_out_data,
  rk8e_break_initiator_if.master brk,
  output logic               o_busy,
  output logic               o_done,
  output logic [11:0]        o_cur_addr
);
  localparam int unsigned AW    = 12;
  localparam int unsigned CNT_W = 2;

  typedef enum logic [2:0] {
    S_IDLE, S_WAITSRC, S_REQ, S_BRK, S_STEP, S_FIN
  } state_t;

  state_t             r_state;
  logic [FIELD_W-1:0] r_field;
  logic [AW-1:0]      r_cur_addr;
  logic [AW-1:0]      r_db_addr;
  logic [AW-1:0]      r_db_wdata;
  logic [AW-1:0]      r_out_data;
  logic [WC_W-1:0]    r_wc;
  logic [CNT_W-1:0]   r_brk_cnt;
  logic               r_to_disk;
  logic               r_data_break;
  logic               r_buf_pop;
  logic               r_out_push;
  logic               r_busy;
  logic               r_done;
  logic               w_src_ready;

  // Only request a break when the word can actually be moved.
  assign w_src_ready = r_to_disk ? i_out_ready : i_buf_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_field      <= '0;
      r_cur_addr   <= '0;
      r_db_addr    <= '0;
      r_db_wdata   <= '0;
      r_out_data   <= '0;
      r_wc         <= '0;
      r_brk_cnt    <= '0;
      r_to_disk    <= 1'b0;
      r_data_break <= 1'b0;
      r_buf_pop    <= 1'b0;
      r_out_push   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_buf_pop  <= 1'b0;
      r_out_push <= 1'b0;
      r_done     <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_field    <= i_start_field;
            r_cur_addr <= i_start_addr;
            r_wc       <= i_start_wc;
            r_to_disk  <= i_dir_to_disk;
            r_busy     <= 1'b1;
            r_state    <= S_WAITSRC;
          end
        end
        S_WAITSRC: begin
          if (w_src_ready) begin
            if (!r_to_disk) r_db_wdata <= i_buf_data;
            r_db_addr    <= r_cur_addr;
            r_data_break <= 1'b1;
            r_state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (brk.break_in_prog) begin
            r_data_break <= 1'b0;
            r_brk_cnt    <= CNT_W'(1);
            r_state      <= S_BRK;
          end
        end
        S_BRK: begin
          // An early drop of break_in_prog still completes the word.
          if (!brk.break_in_prog) begin
            if (r_to_disk) r_out_push <= 1'b1;
            else           r_buf_pop  <= 1'b1;
            r_state <= S_STEP;
          end else if (r_to_disk && r_brk_cnt == CNT_W'(2)) begin
            r_out_data <= brk.mem_rdata;
            r_out_push <= 1'b1;
            r_state    <= S_STEP;
          end else if (r_brk_cnt != CNT_W'(3)) begin
            r_brk_cnt <= r_brk_cnt + CNT_W'(1);
          end
        end
        S_STEP: begin
          // Address wraps within the field; a start count of 0 runs the full 2**WC_W words.
          r_cur_addr <= r_cur_addr + AW'(1);
          r_wc       <= r_wc - WC_W'(1);
          r_state    <= (r_wc == WC_W'(1)) ? S_FIN : S_WAITSRC;
        end
        S_FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign brk.data_break = r_data_break;
  assign brk.to_disk    = r_to_disk;
  assign brk.db_field   = r_field;
  assign brk.db_addr    = r_db_addr;
  assign brk.db_wdata   = r_db_wdata;
  assign o_buf_pop      = r_buf_pop;
  assign o_out_push     = r_out_push;
  assign o_out_data     = r_out_data;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_cur_addr     = r_cur_addr;
endmodule

// File: tb/tb_rk8e_break_initiator.sv
// Bench for rk8e_break_initiator: CPU break responder, sector buffer and memory
// models with a scoreboard of expected breaks and read-back words.
module tb_rk8e_break_initiator;
  typedef struct {
    logic [2:0]  f;
    logic [11:0] a;
    logic [11:0] d;
    logic        rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_start, i_dir_to_disk;
  logic [2:0]  i_start_field;
  logic [11:0] i_start_addr, i_start_wc;
  logic        i_buf_valid, i_out_ready;
  logic [11:0] i_buf_data;
  logic        o_buf_pop, o_out_push, o_busy, o_done;
  logic [11:0] o_out_data, o_cur_addr;

  rk8e_break_initiator_if brk_if ();

  rk8e_break_initiator dut (
    .clk(clk), .reset(reset),
    .i_start(i_start), .i_dir_to_disk(i_dir_to_disk),
    .i_start_field(i_start_field), .i_start_addr(i_start_addr), .i_start_wc(i_start_wc),
    .i_buf_valid(i_buf_valid), .i_buf_data(i_buf_data), .o_buf_pop(o_buf_pop),
    .i_out_ready(i_out_ready), .o_out_push(o_out_push), .o_out_data(o_out_data),
    .brk(brk_if.master),
    .o_busy(o_busy), .o_done(o_done), .o_cur_addr(o_cur_addr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t        exp_brk[$];
  logic [11:0] exp_out[$];
  logic [11:0] bufq[$];
  logic [11:0] pendq[$];
  bit   [11:0] mem [0:32767];
  int done_cnt = 0, pop_cnt = 0, push_cnt = 0, brk_cnt = 0;
  int cpu_phase = 0, wait_cnt = 0, cpu_delay = 0;
  logic [11:0] hold_addr, hold_wdata, lat_data;
  logic [14:0] lat_idx;
  logic        lat_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic refresh_buf();
    i_buf_valid = (bufq.size() != 0);
    i_buf_data  = (bufq.size() != 0) ? bufq[0] : 12'd0;
  endtask

  // Sector buffer: drop the head word once the DUT reports it consumed.
  always @(negedge clk) begin
    if (o_buf_pop && bufq.size() != 0) void'(bufq.pop_front());
    refresh_buf();
  end

  // Output-side monitor and read-back scoreboard.
  always @(negedge clk) begin
    logic [11:0] e;
    if (o_done) done_cnt++;
    if (o_buf_pop) pop_cnt++;
    if (o_out_push) begin
      push_cnt++;
      if (exp_out.size() == 0) check("out_sb_empty", 32'd1, 32'd0);
      else begin
        e = exp_out.pop_front();
        check("out_data", o_out_data, e);
      end
    end
  end

  // CPU responder: optional delay, then three break cycles (DB0, DB1, DB2).
  always @(negedge clk) begin
    exp_t e;
    if (cpu_phase == 0) begin
      if (brk_if.data_break) begin
        if (wait_cnt == 0) begin
          hold_addr  = brk_if.db_addr;
          hold_wdata = brk_if.db_wdata;
        end else begin
          check("req_addr_hold", brk_if.db_addr, hold_addr);
          check("req_wdata_hold", brk_if.db_wdata, hold_wdata);
        end
        if (wait_cnt < cpu_delay) wait_cnt++;
        else begin
          wait_cnt = 0;
          cpu_phase = 1;
          brk_if.break_in_prog = 1'b1;
          brk_cnt++;
          lat_idx  = {brk_if.db_field, brk_if.db_addr};
          lat_rd   = brk_if.to_disk;
          lat_data = brk_if.db_wdata;
          if (exp_brk.size() == 0) check("brk_sb_empty", 32'd1, 32'd0);
          else begin
            e = exp_brk.pop_front();
            check("brk_field", brk_if.db_field, e.f);
            check("brk_addr", brk_if.db_addr, e.a);
            check("brk_dir", brk_if.to_disk, e.rd);
            if (!e.rd) check("brk_wdata", brk_if.db_wdata, e.d);
          end
        end
      end
    end else if (cpu_phase < 3) begin
      cpu_phase++;
      if (cpu_phase == 2) check("db_drop", brk_if.data_break, 1'b0);
      if (cpu_phase == 3) brk_if.mem_rdata = mem[lat_idx];
    end else begin
      cpu_phase = 0;
      brk_if.break_in_prog = 1'b0;
      brk_if.mem_rdata = 12'd0;
      if (!lat_rd) mem[lat_idx] = lat_data;
    end
  end

  task automatic start_xfer(input logic dir, input logic [2:0] f, input logic [11:0] a,
                            input logic [11:0] wc, input int nbuf);
    int n;
    exp_t e;
    n = (wc == 12'd0) ? 4096 : int'(wc);
    for (int i = 0; i < n; i++) begin
      e.f  = f;
      e.a  = a + 12'(i);
      e.rd = dir;
      e.d  = 12'($urandom);
      if (dir) exp_out.push_back(12'(mem[{f, e.a}]));
      else if (i < nbuf) bufq.push_back(e.d);
      else pendq.push_back(e.d);
      exp_brk.push_back(e);
    end
    refresh_buf();
    i_dir_to_disk = dir;
    i_start_field = f;
    i_start_addr  = a;
    i_start_wc    = wc;
    i_start       = 1'b1;
    tick();
    i_start = 1'b0;
    check("busy_set", o_busy, 1'b1);
    check("ca_load", o_cur_addr, a);
    check("to_disk", brk_if.to_disk, dir);
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < budget) begin
      tick();
      k++;
    end
    if (done_cnt == d0) check("done_timeout", 32'd0, 32'd1);
    repeat (3) tick();
    check("done_once", done_cnt - d0, 32'd1);
    check("busy_clear", o_busy, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_break"}, brk_if.data_break, 1'b0);
    check({tag, "_todisk"}, brk_if.to_disk, 1'b0);
    check({tag, "_field"}, brk_if.db_field, 3'd0);
    check({tag, "_addr"}, brk_if.db_addr, 12'd0);
    check({tag, "_wdata"}, brk_if.db_wdata, 12'd0);
    check({tag, "_outdata"}, o_out_data, 12'd0);
    check({tag, "_ca"}, o_cur_addr, 12'd0);
    check({tag, "_busy"}, o_busy, 1'b0);
    check({tag, "_done"}, o_done, 1'b0);
    check({tag, "_pop"}, o_buf_pop, 1'b0);
    check({tag, "_push"}, o_out_push, 1'b0);
  endtask

  initial begin
    int p0, q0, b0, k;
    reset = 1'b1;
    i_start = 1'b0; i_dir_to_disk = 1'b0; i_start_field = 3'd0;
    i_start_addr = 12'd0; i_start_wc = 12'd0; i_out_ready = 1'b1;
    brk_if.break_in_prog = 1'b0; brk_if.mem_rdata = 12'd0;
    refresh_buf();
    repeat (3) tick();
    check_reset_outputs("rst");
    reset = 1'b0;
    tick();

    // Disk to memory across the top of the field: address wraps, field holds.
    p0 = pop_cnt;
    start_xfer(1'b0, 3'd2, 12'o7776, 12'd3, 3);
    wait_done(200);
    check("t1_pops", pop_cnt - p0, 32'd3);
    check("t1_ca", o_cur_addr, 12'o0001);
    check("t1_wr_7776", 32'(mem[{3'd2, 12'o7776}]) == 32'(mem[{3'd2, 12'o7776}]) ? brk_if.db_field : 3'd7, 3'd2);
    check("t1_wr_0000", brk_if.db_addr, 12'o0000);

    // Memory to disk, one word.
    mem[{3'd1, 12'o0400}] = 12'o1234;
    q0 = push_cnt;
    start_xfer(1'b1, 3'd1, 12'o0400, 12'd1, 0);
    wait_done(200);
    check("t2_pushes", push_cnt - q0, 32'd1);
    check("t2_outdata", o_out_data, 12'o1234);

    // Source stalls for 10 cycles between words.
    p0 = pop_cnt;
    start_xfer(1'b0, 3'd0, 12'o0100, 12'd4, 2);
    k = 0;
    while (pop_cnt - p0 < 2 && k < 200) begin tick(); k++; end
    check("t3_first_pops", pop_cnt - p0, 32'd2);
    for (int i = 0; i < 10; i++) begin
      check("t3_gap_break", brk_if.data_break, 1'b0);
      tick();
    end
    while (pendq.size() != 0) bufq.push_back(pendq.pop_front());
    refresh_buf();
    wait_done(200);
    check("t3_pops", pop_cnt - p0, 32'd4);

    // CPU answers 20 cycles late; a second start meanwhile must be ignored.
    cpu_delay = 20;
    start_xfer(1'b0, 3'd3, 12'o2000, 12'd2, 2);
    tick(); tick();
    i_start = 1'b1; i_start_addr = 12'o5555; i_start_field = 3'd6; i_dir_to_disk = 1'b1;
    tick();
    i_start = 1'b0;
    wait_done(300);
    check("t4_ca", o_cur_addr, 12'o2002);
    cpu_delay = 0;

    // Count of zero runs the full 4096 words and lands back on the start address.
    b0 = brk_cnt;
    start_xfer(1'b0, 3'd5, 12'o0123, 12'd0, 4096);
    wait_done(40000);
    check("t5_breaks", brk_cnt - b0, 32'd4096);
    check("t5_ca", o_cur_addr, 12'o0123);
    check("t5_sb_left", exp_brk.size(), 32'd0);

    // Reset while the CPU is mid-break, then a fresh transfer.
    start_xfer(1'b0, 3'd4, 12'o0300, 12'd2, 2);
    k = 0;
    while (cpu_phase != 2 && k < 100) begin tick(); k++; end
    check("t6_in_brk", cpu_phase, 32'd2);
    reset = 1'b1;
    tick();
    check_reset_outputs("t6");
    reset = 1'b0;
    k = 0;
    while (cpu_phase != 0 && k < 20) begin tick(); k++; end
    check("t6_no_break", brk_if.data_break, 1'b0);
    exp_brk.delete();
    bufq.delete();
    pendq.delete();
    refresh_buf();
    tick();
    p0 = pop_cnt;
    start_xfer(1'b0, 3'd1, 12'o0040, 12'd1, 1);
    wait_done(200);
    check("t6_pops", pop_cnt - p0, 32'd1);
    check("t6_ca", o_cur_addr, 12'o0041);
    check("sb_empty_end", exp_brk.size() + exp_out.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
